neuron_accumulator: RTL
=======================

Name: neuron_accumulator

Overview:
- Consumer end of the per-neuron product array: takes the 33 signed 32-bit lanes from the multiplier stage (32 weighted inputs plus the bias lane 32) and reduces them to one neuron pre-activation sum.
- Reduces sequentially, LANES_PER_CYCLE lanes per clock, to bound adder area.
- Output is saturated to 32 bits, with optional ReLU, and delivered through a valid/ready handshake to the next layer.

Parameters:
- LANES_PER_CYCLE, 1, lanes summed per ACCUM cycle; legal range 1..33.
- ACC_W, 40, internal accumulator width in bits; must be >= 38.
- RELU, 0, 1 = clamp negative results to 0 after saturation.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  product vector valid.
- in_ready  output  1  block can accept a vector.
- in_prod  input  33x32 (packed [32:0][31:0])  signed products; lane 32 = bias.
- in_enable  input  33  per-lane mask; bit 32 is ignored (bias lane is always enabled).
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  32  signed saturated (optionally ReLU'd) sum.
- out_overflow  output  1  saturation occurred for this result.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - state = IDLE.
  - in_ready = 1, out_valid = 0, out_sum = 0, out_overflow = 0.
  - Group counter = 0, accumulator = 0.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: latch in_prod and effective mask (in_enable[31:0], bit 32 forced to 1).
  - Clear accumulator and group counter; next state ACCUM.
- ACCUM:
  - in_ready = 0.
  - Each cycle, add the sign-extended (to ACC_W) lanes g*L .. g*L+L-1, where L = LANES_PER_CYCLE and g = group counter.
  - Masked-off lanes and lane indices > 32 contribute 0.
  - Group counter increments by 1 each cycle.
  - After group G-1 is added (G = ceil(33/L)), next state DONE.
- DONE:
  - out_valid = 1.
  - out_sum = sat32(acc), then, if RELU, max(0, ·).
  - out_overflow = 1 iff acc > 2^31-1 or acc < -2^31.
  - Outputs are registered and stable while out_valid && !out_ready.
  - On out_ready: out_valid deasserts next cycle; next state IDLE.
- Latency:
  - Accept edge to out_valid high = G cycles.
  - L=1: 33; L=4: 9; L=33: 1.
  - Minimum throughput: one vector per G+2 cycles. No overlap; in_ready is 0 in ACCUM and DONE.
- Arithmetic:
  - Two's complement throughout.
  - ACC_W >= 38 guarantees no internal wrap (33 * 2^31 < 2^37).
  - Saturation happens once, at the end.
  - ReLU is applied after saturation; out_overflow reflects saturation only, not ReLU clamping.
- in_prod and in_enable changes outside the accept cycle are ignored (lanes are latched).
- in_valid held high through ACCUM and DONE is not consumed until the block returns to IDLE.
- Reset asserted mid-ACCUM or mid-DONE: immediate return to reset values. The partial result is discarded and no out_valid pulse is produced.
- out_sum and out_overflow hold their last value after the DONE handshake until the next DONE, so they are only meaningful while out_valid is high.

Test Plan:
- L=1, all lanes = 1, in_enable = all ones -> out_valid exactly 33 cycles after accept; out_sum = 33; out_overflow = 0.
- L=4, in_enable = 0, lane 32 = 0xFFFFFFFE, other lanes = 0x12345678 -> out_sum = 0xFFFFFFFE (-2); out_valid after 9 cycles; bias lane not maskable.
- All lanes = 0x7FFFFFFF, all enabled -> out_sum = 0x7FFFFFFF, out_overflow = 1.
- All lanes = 0x80000000, all enabled -> out_sum = 0x80000000, out_overflow = 1.
- RELU=1, lanes 0..31 = -5 enabled, lane 32 = 3 -> out_sum = 0, out_overflow = 0.
- Backpressure: hold out_ready = 0 for 6 cycles in DONE -> out_valid, out_sum and out_overflow stable and in_ready = 0. Then out_ready = 1 -> in_ready = 1 on the following cycle, and a back-to-back vector is accepted.
- Reset pulse at ACCUM group 10 (L=1) -> all outputs return to reset values immediately. A subsequent vector then gives its correct sum with no residue from the aborted one.

Source files
------------

// File: rtl/neuron_accumulator.sv
// neuron_accumulator: sequential reduction of 33 signed 32-bit product lanes
// (32 weighted inputs + bias lane 32) into one saturated, optionally ReLU'd
// pre-activation sum, delivered over a valid/ready handshake.
//
//   state | meaning
//   IDLE  | ready for a new product vector
//   ACCUM | summing LANES_PER_CYCLE latched lanes per clock
//   DONE  | result valid, waiting for downstream ready
module neuron_accumulator #(
  parameter int LANES_PER_CYCLE = 1,
  parameter int ACC_W           = 40,
  parameter int RELU            = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [32:0][31:0] in_prod,
  input  logic [32:0]      in_enable,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_sum,
  output logic             out_overflow
);

  localparam int L  = LANES_PER_CYCLE;
  localparam int G  = (33 + L - 1) / L;
  localparam int GW = (G > 1) ? $clog2(G) : 1;
  localparam logic [GW-1:0] LAST_GRP = GW'(G - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-31){1'b0}}, {31{1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-31){1'b1}}, {31{1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [32:0][31:0]       r_prod;
  logic [32:0]             r_mask;
  logic [GW-1:0]           r_grp;
  logic signed [ACC_W-1:0] r_acc;
  logic [31:0]             r_sum;
  logic                    r_ovf;

  logic signed [ACC_W-1:0] w_part;
  logic signed [ACC_W-1:0] w_acc_next;
  logic [6:0]              w_idx;
  logic [31:0]             w_sum;
  logic                    w_ovf;
  logic                    w_accept;
  logic                    w_last;
  logic                    w_unused;

  // Bias lane is never maskable, so the incoming bit 32 has no effect.
  assign w_unused = in_enable[32];

  assign in_ready     = (r_state == IDLE);
  assign out_valid    = (r_state == DONE);
  assign out_sum      = r_sum;
  assign out_overflow = r_ovf;
  assign w_accept     = in_valid && (r_state == IDLE);
  assign w_last       = (r_grp == LAST_GRP);

  // Sum the enabled lanes of the current group; indices past 32 contribute 0.
  always_comb begin
    w_part = '0;
    w_idx  = '0;
    for (int j = 0; j < L; j++) begin
      w_idx = 7'(r_grp) * 7'(L) + 7'(j);
      if ((w_idx <= 7'd32) && r_mask[w_idx[5:0]]) begin
        w_part = w_part + {{(ACC_W-32){r_prod[w_idx[5:0]][31]}}, r_prod[w_idx[5:0]]};
      end
    end
    w_acc_next = r_acc + w_part;
  end

  // Saturate the final accumulator to 32 bits, then optional ReLU clamp.
  always_comb begin
    w_ovf = 1'b0;
    w_sum = w_acc_next[31:0];
    if (w_acc_next > SAT_MAX) begin
      w_ovf = 1'b1;
      w_sum = 32'h7FFF_FFFF;
    end else if (w_acc_next < SAT_MIN) begin
      w_ovf = 1'b1;
      w_sum = 32'h8000_0000;
    end
    if ((RELU != 0) && w_sum[31]) begin
      w_sum = '0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept)  w_next = ACCUM;
      ACCUM:   if (w_last)    w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Lane latch, accumulation and result register; result only loads on the
  // last group so it holds steady through DONE and afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prod <= '0;
      r_mask <= '0;
      r_grp  <= '0;
      r_acc  <= '0;
      r_sum  <= '0;
      r_ovf  <= 1'b0;
    end else if (w_accept) begin
      r_prod <= in_prod;
      r_mask <= {1'b1, in_enable[31:0]};
      r_grp  <= '0;
      r_acc  <= '0;
    end else if (r_state == ACCUM) begin
      r_acc <= w_acc_next;
      r_grp <= r_grp + GW'(1);
      if (w_last) begin
        r_sum <= w_sum;
        r_ovf <= w_ovf;
      end
    end
  end

endmodule
